// File: rtl/trb_capture_ctrl.sv
// Trace buffer sequencer: circular trace capture with post-trigger delay, and
// sequential stream readout of the single-port trace RAM.
module trb_capture_ctrl #(
  parameter int TRB_WIDTH      = 32,
  parameter int TRB_DEPTH      = 64,
  parameter int TRB_DELAY_BITS = 16,
  localparam int AW            = $clog2(TRB_DEPTH)
) (
  input  logic                      FPGA_CLK_I,
  input  logic                      RST_NI,
  input  logic                      EN_I,
  input  logic                      MODE_I,
  input  logic [TRB_DELAY_BITS-1:0] TRG_DELAY_I,
  input  logic [AW:0]               STREAM_LEN_I,
  input  logic                      TRG_EVENT_I,
  input  logic                      STORE_I,
  input  logic                      LOAD_I,
  input  logic [TRB_WIDTH-1:0]      DATA_I,
  output logic                      TRG_EVENT_O,
  output logic                      LOAD_O,
  output logic [TRB_WIDTH-1:0]      DATA_O,
  output logic                      MEM_WE_O,
  output logic [AW-1:0]             MEM_ADDR_O,
  output logic [TRB_WIDTH-1:0]      MEM_WDATA_O,
  input  logic [TRB_WIDTH-1:0]      MEM_RDATA_I,
  output logic [AW-1:0]             TRG_ADDR_O,
  output logic                      WRAPPED_O,
  output logic                      DONE_O
);

  // Bit 2 of the state encodes the mode: 0 trace, 1 stream.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_POST  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_SIDLE = 3'd4;
  localparam logic [2:0] ST_SADDR = 3'd5;
  localparam logic [2:0] ST_SDATA = 3'd6;
  localparam logic [2:0] ST_SEND  = 3'd7;

  localparam logic [AW-1:0] WR_LAST = AW'(TRB_DEPTH - 1);

  logic [2:0]                state_q, state_d;
  logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [AW:0]               rd_ptr_q, rd_ptr_d;
  logic [TRB_DELAY_BITS-1:0] cnt_q, cnt_d;
  logic [AW-1:0]             trg_addr_q, trg_addr_d;
  logic                      wrapped_q, wrapped_d;
  logic [TRB_WIDTH-1:0]      data_q, data_d;

  logic                      in_stream;
  logic                      abort;
  logic                      mem_we;
  logic [AW-1:0]             mem_addr;
  logic [TRB_WIDTH-1:0]      mem_wdata;

  assign in_stream = state_q[2];
  assign abort     = (state_q != ST_IDLE) && (!EN_I || (MODE_I != in_stream));

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    trg_addr_d = trg_addr_q;
    wrapped_d  = wrapped_q;
    data_d     = data_q;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    // Capture writes go straight to the RAM so it samples on the STORE_I edge.
    if (state_q == ST_ARMED || state_q == ST_POST) begin
      mem_we    = STORE_I && !abort;
      mem_addr  = wr_ptr_q;
      mem_wdata = DATA_I;
      if (STORE_I) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (wr_ptr_q == WR_LAST) wrapped_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        wr_ptr_d   = '0;
        rd_ptr_d   = '0;
        cnt_d      = '0;
        trg_addr_d = '0;
        wrapped_d  = 1'b0;
        data_d     = '0;
        if (EN_I) state_d = MODE_I ? ST_SIDLE : ST_ARMED;
      end
      ST_ARMED: begin
        if (TRG_EVENT_I) begin
          trg_addr_d = wr_ptr_q;
          state_d    = ST_POST;
          // A store coinciding with the trigger already counts as the first post store.
          if (STORE_I) begin
            if (TRG_DELAY_I == '0) state_d = ST_DONE;
            else                   cnt_d   = TRG_DELAY_I - 1'b1;
          end else begin
            cnt_d = TRG_DELAY_I;
          end
        end
      end
      ST_POST: begin
        if (STORE_I) begin
          if (cnt_q == '0) state_d = ST_DONE;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      ST_SIDLE: begin
        if (LOAD_I && (rd_ptr_q < STREAM_LEN_I)) state_d = ST_SADDR;
      end
      ST_SADDR: begin
        mem_addr = rd_ptr_q[AW-1:0];
        state_d  = ST_SDATA;
      end
      ST_SDATA: begin
        data_d   = MEM_RDATA_I;
        rd_ptr_d = rd_ptr_q + 1'b1;
        state_d  = ST_SEND;
      end
      ST_SEND: state_d = ST_SIDLE;
      default: state_d = state_q;
    endcase

    if (abort) begin
      state_d    = ST_IDLE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
      trg_addr_d = '0;
      wrapped_d  = 1'b0;
    end
  end

  always_ff @(posedge FPGA_CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      trg_addr_q <= '0;
      wrapped_q  <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      trg_addr_q <= trg_addr_d;
      wrapped_q  <= wrapped_d;
      data_q     <= data_d;
    end
  end

  assign MEM_WE_O    = mem_we;
  assign MEM_ADDR_O  = mem_addr;
  assign MEM_WDATA_O = mem_wdata;
  assign TRG_EVENT_O = (state_q == ST_DONE);
  assign DONE_O      = (state_q == ST_DONE) ||
                       ((state_q == ST_SIDLE) && (rd_ptr_q == STREAM_LEN_I));
  assign LOAD_O      = (state_q == ST_SEND);
  assign DATA_O      = in_stream ? data_q : '0;
  assign TRG_ADDR_O  = trg_addr_q;
  assign WRAPPED_O   = wrapped_q;

endmodule
